spi_shift_engine: RTL and testbench
===================================

// Module: spi_shift_engine
// PURPOSE
//  Parametrised full-duplex shift engine for the SPI datapath. Loads a word, shifts it out on
//  1/2/4 lanes (single/dual/quad) while capturing the same number of bits from the input lanes.
//  Transfer length is set per load, and a down-counter signals completion. It sits between the
//  cache-side command/data logic and the SPI pin sequencer, which supplies shift_en per SCK edge.
// PARAMETERS
//  SIZE       32  maximum transfer length in bits (>=4, multiple of 4)
//  MSB_FIRST  1   1: MSB shifted first; 0: load and rx words bit-reversed (LSB first on the wire)
// PORTS
//  clk         in   1                  clock, all state updates on rising edge
//  rst_n       in   1                  asynchronous, active-low reset
//  load_valid  in   1                  load request
//  load_ready  out  1                  engine idle, able to accept a load
//  load_data   in   SIZE               word to transmit
//  load_len    in   $clog2(SIZE+1)     bits to transfer; values >SIZE are clamped to SIZE
//  load_mode   in   2                  00: 1 lane, 01: 2 lanes, 10: 4 lanes, 11: reserved (=1 lane)
//  shift_en    in   1                  advance one lane-group (W bits) this cycle
//  abort       in   1                  synchronous cancel of the current transfer
//  sdi         in   4                  input lanes; only sdi[W-1:0] used
//  sdo         out  4                  output lanes; only sdo[W-1:0] driven, others 0
//  busy        out  1                  transfer in progress (state SHIFT)
//  done        out  1                  one-cycle pulse at transfer completion
//  rx_data     out  SIZE               received bits, right-aligned, upper bits 0; held until next load
//  rx_len      out  $clog2(SIZE+1)     length of the completed transfer
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; shift reg, counter, mode, rx_data, rx_len = 0;
//    load_ready=1, busy=0, done=0, sdo=0. Reset mid-transfer drops it with no done pulse.
//  - States: IDLE -> SHIFT (load accepted, len>0); IDLE -> FIN (load accepted, len=0);
//    SHIFT -> FIN (shift that takes cnt to 0); SHIFT -> IDLE (abort); FIN -> IDLE (always).
//  - load_ready = (state==IDLE). The load is accepted on load_valid&&load_ready. At acceptance:
//    reg <= load_data (bit-reversed if !MSB_FIRST); cnt <= min(load_len,SIZE); W latched from
//    load_mode. A load_valid in SHIFT or FIN is ignored, and the shift reg stays unchanged.
//  - The load data is left-aligned. If the caller sends len<SIZE, the caller puts the data in
//    the upper len bits.
//  - sdo in SHIFT: sdo[W-1:0] = reg[SIZE-1 -: W] (sdo[W-1] = reg[SIZE-1]). Output is
//    combinational from the reg. sdo=0 outside SHIFT.
//  - Shift (state SHIFT && shift_en && !abort): reg <= {reg[SIZE-W-1:0], sdi[W-1:0]}, with
//    sdi[W-1] the more significant. cnt <= cnt - min(W,cnt). For the final partial group
//    (cnt<W), only the top cnt bits of sdi are kept: reg shifts by cnt, not W.
//  - shift_en outside SHIFT: no effect. abort has priority over shift_en in the same cycle.
//  - Abort: SHIFT -> IDLE next cycle, no done, rx_data/rx_len unchanged. Abort in IDLE/FIN: ignored.
//  - FIN (exactly 1 cycle): done=1, busy=0, load_ready=0. rx_data <= reg & ((1<<len)-1),
//    bit-reversed within the low len bits if !MSB_FIRST. rx_len <= len. For len=0: rx_data=0.
//  - Latency: load accept -> busy high on the next cycle. The last shift -> done high on the
//    next cycle. A new load is accepted one cycle after done (back-to-back).
//  - cnt width is $clog2(SIZE+1), so len=SIZE is representable. cnt never underflows.
// TESTING
//  1) 1-lane, len=8, data=0xA5<<24, sdi[0] drives 0x3C MSB-first, 8 shift_en ->
//     sdo[0]=1,0,1,0,0,1,0,1. done after the 8th, rx_data=0x0000003C, rx_len=8.
//  2) Quad, len=32, data=0xDEADBEEF, sdi=nibbles of 0x12345678 -> sdo=D,E,A,D,B,E,E,F;
//     done after 8 shifts; rx_data=0x12345678.
//  3) Quad, len=6, data=0xB4000000 (101101), sdi=F then F -> sdo=B then 0b01xx; done after 2
//     shifts; rx_data=0x3F.
//  4) len=0 load -> no busy, done pulse 1 cycle after accept, rx_data=0. len=40 -> clamped to 32.
//  5) Abort after 3 of 8 shifts -> IDLE, no done, rx_data keeps its previous value. A load_valid
//     during SHIFT is ignored, and the shift reg stays unchanged.
//  6) rst_n low mid-SHIFT (asynchronously, between edges) -> all outputs 0 and load_ready=1
//     immediately. After release, a fresh 1-lane transfer completes correctly with
//     MSB_FIRST=0 (0x01 in the low bits is sent as the 1 first).

Source files
------------

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module  : spi_shift_engine
//  Purpose : Full-duplex SPI shift engine. A loaded word is shifted out on
//            1, 2 or 4 lanes while the same number of bits is captured from
//            the input lanes. A down-counter tracks the remaining bits and a
//            one-cycle done pulse reports completion with the received word.
//  Ports   : clk, rst_n            clock / async active-low reset
//            load_valid/ready      load handshake (ready only when idle)
//            load_data/len/mode    word, bit count (clamped to SIZE), lanes
//            shift_en, abort       advance one lane group / cancel transfer
//            sdi, sdo              4-bit input / output lanes
//            busy, done            shifting / completion pulse
//            rx_data, rx_len       received word (right-aligned) and length
//  Revision: 1.0 - initial release
// ============================================================================
module spi_shift_engine #(
  parameter int SIZE      = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [SIZE-1:0]            load_data,
  input  logic [$clog2(SIZE+1)-1:0]  load_len,
  input  logic [1:0]                 load_mode,
  input  logic                       shift_en,
  input  logic                       abort,
  input  logic [3:0]                 sdi,
  output logic [3:0]                 sdo,
  output logic                       busy,
  output logic                       done,
  output logic [SIZE-1:0]            rx_data,
  output logic [$clog2(SIZE+1)-1:0]  rx_len
);

  localparam int LW = $clog2(SIZE+1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] sreg_q, sreg_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic [2:0]      lanes_q, lanes_d;      // active lane count: 1, 2 or 4
  logic [SIZE-1:0] rx_data_q, rx_data_d;
  logic [LW-1:0]   rx_len_q, rx_len_d;

  logic [LW-1:0]   len_clamped;
  logic [LW-1:0]   step;
  logic [3:0]      sdi_used;
  logic [3:0]      sdi_top;
  logic [SIZE-1:0] rx_masked;
  logic [SIZE-1:0] rx_word;

  function automatic logic [SIZE-1:0] bit_rev(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE; i++) begin
      r[i] = v[SIZE-1-i];
    end
    return r;
  endfunction

  assign len_clamped = (load_len > LW'(SIZE)) ? LW'(SIZE) : load_len;

  // Only the lanes in use contribute; a short final group keeps just the
  // most significant 'step' bits of that group.
  always_comb begin
    sdi_used = 4'd0;
    case (lanes_q)
      3'd2:    sdi_used = {2'b00, sdi[1:0]};
      3'd4:    sdi_used = sdi;
      default: sdi_used = {3'b000, sdi[0]};
    endcase
  end

  assign step    = (cnt_q < LW'(lanes_q)) ? cnt_q : LW'(lanes_q);
  assign sdi_top = sdi_used >> (lanes_q - step[2:0]);

  // After the last shift the received bits sit in the low len bits of the
  // shift register, first-received bit most significant.
  assign rx_masked = sreg_q & ~({SIZE{1'b1}} << len_q);
  assign rx_word   = MSB_FIRST ? rx_masked
                               : (bit_rev(rx_masked) >> (LW'(SIZE) - len_q));

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    lanes_d   = lanes_q;
    rx_data_d = rx_data_q;
    rx_len_d  = rx_len_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          sreg_d  = MSB_FIRST ? load_data : bit_rev(load_data);
          cnt_d   = len_clamped;
          len_d   = len_clamped;
          case (load_mode)
            2'b01:   lanes_d = 3'd2;
            2'b10:   lanes_d = 3'd4;
            default: lanes_d = 3'd1;
          endcase
          state_d = (len_clamped == '0) ? ST_FIN : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (shift_en) begin
          sreg_d = (sreg_q << step) | SIZE'(sdi_top);
          cnt_d  = cnt_q - step;
          if (cnt_q == step) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d   = ST_IDLE;
        rx_data_d = rx_word;
        rx_len_d  = len_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      lanes_q   <= '0;
      rx_data_q <= '0;
      rx_len_q  <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      lanes_q   <= lanes_d;
      rx_data_q <= rx_data_d;
      rx_len_q  <= rx_len_d;
    end
  end

  always_comb begin
    sdo = 4'd0;
    if (state_q == ST_SHIFT) begin
      case (lanes_q)
        3'd2:    sdo = {2'b00, sreg_q[SIZE-1 -: 2]};
        3'd4:    sdo = sreg_q[SIZE-1 -: 4];
        default: sdo = {3'b000, sreg_q[SIZE-1]};
      endcase
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_SHIFT);
  assign done       = (state_q == ST_FIN);
  assign rx_data    = rx_data_q;
  assign rx_len     = rx_len_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module  : tb_spi_shift_engine
//  Purpose : Self-checking bench for spi_shift_engine. Two instances (MSB
//            first and LSB first) share all inputs. A wire-level model (ring
//            buffer of bits in transmit order) predicts every output each
//            cycle; directed sequences add literal expectations.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;

  localparam int SIZE = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic [5:0]  load_len = '0;
  logic [1:0]  load_mode = '0;
  logic        shift_en = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  sdi = '0;

  logic        lr_w   [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic [3:0]  sdo_w  [2];
  logic [31:0] rx_w   [2];
  logic [5:0]  rxl_w  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_shift_engine #(.SIZE(SIZE), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr_w[0]),
    .load_data(load_data), .load_len(load_len), .load_mode(load_mode),
    .shift_en(shift_en), .abort(abort), .sdi(sdi), .sdo(sdo_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .rx_data(rx_w[0]), .rx_len(rxl_w[0])
  );

  spi_shift_engine #(.SIZE(SIZE), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr_w[1]),
    .load_data(load_data), .load_len(load_len), .load_mode(load_mode),
    .shift_en(shift_en), .abort(abort), .sdi(sdi), .sdo(sdo_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .rx_data(rx_w[1]), .rx_len(rxl_w[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mst: 0 idle, 1 shifting, 2 finishing. strm[m] is the wire-order bit
  // stream of instance m (0 = MSB first, 1 = LSB first); bits sent leave the
  // front and received bits join the back.
  int          mst = 0, mcnt = 0, mlen = 0, mw = 1, head = 0, got = 0;
  bit          strm [2][SIZE];
  bit          rxbits [SIZE];
  logic [31:0] rx_exp [2] = '{32'd0, 32'd0};
  int          rxlen_exp = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst = 0; mcnt = 0; mlen = 0; head = 0; got = 0;
      rx_exp[0] = 0; rx_exp[1] = 0; rxlen_exp = 0;
    end else begin
      case (mst)
        0: if (load_valid) begin
          mlen = (int'(load_len) > SIZE) ? SIZE : int'(load_len);
          mw   = (load_mode == 2'b01) ? 2 : (load_mode == 2'b10) ? 4 : 1;
          for (int i = 0; i < SIZE; i++) begin
            strm[0][i] = load_data[SIZE-1-i];
            strm[1][i] = load_data[i];
          end
          head = 0; got = 0; mcnt = mlen;
          mst  = (mlen == 0) ? 2 : 1;
        end
        1: if (abort) begin
          mst = 0;
        end else if (shift_en) begin
          int n;
          n = (mcnt < mw) ? mcnt : mw;
          for (int j = 0; j < n; j++) begin
            bit b;
            b = sdi[mw-1-j];
            strm[0][(head+j)%SIZE] = b;
            strm[1][(head+j)%SIZE] = b;
            rxbits[got+j] = b;
          end
          head = (head + n) % SIZE;
          got  = got + n;
          mcnt = mcnt - n;
          if (mcnt == 0) mst = 2;
        end
        default: begin
          mst = 0;
          rx_exp[0] = 0; rx_exp[1] = 0;
          for (int k = 0; k < mlen; k++) begin
            if (rxbits[k]) begin
              rx_exp[0] = rx_exp[0] | (32'd1 << (mlen-1-k));
              rx_exp[1] = rx_exp[1] | (32'd1 << k);
            end
          end
          rxlen_exp = mlen;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [3:0] e;
      e = 4'd0;
      if (mst == 1)
        for (int i = 0; i < mw; i++) e[mw-1-i] = strm[m][(head+i)%SIZE];
      chk($sformatf("m%0d load_ready", m), 64'(lr_w[m]),   64'(mst == 0));
      chk($sformatf("m%0d busy", m),       64'(busy_w[m]), 64'(mst == 1));
      chk($sformatf("m%0d done", m),       64'(done_w[m]), 64'(mst == 2));
      chk($sformatf("m%0d sdo", m),        64'(sdo_w[m]),  64'(e));
      chk($sformatf("m%0d rx_data", m),    64'(rx_w[m]),   64'(rx_exp[m]));
      chk($sformatf("m%0d rx_len", m),     64'(rxl_w[m]),  64'(rxlen_exp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_load(input logic [31:0] d, input logic [5:0] l, input logic [1:0] md);
    load_data = d; load_len = l; load_mode = md; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  a5, x3c;
    logic [31:0] dbe, x1234;
    a5 = 8'hA5; x3c = 8'h3C; dbe = 32'hDEADBEEF; x1234 = 32'h12345678;

    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset load_ready", 64'(lr_w[0]), 64'd1);
    chk("reset rx_data", 64'(rx_w[0]), 64'd0);

    // single lane, 8 bits
    do_load(32'hA500_0000, 6'd8, 2'b00);
    for (int i = 0; i < 8; i++) begin
      chk("t1 sdo", 64'(sdo_w[0][0]), 64'(a5[7-i]));
      sdi = {3'b000, x3c[7-i]}; shift_en = 1'b1;
      step();
    end
    shift_en = 1'b0;
    chk("t1 done", 64'(done_w[0]), 64'd1);
    step();
    chk("t1 rx_data", 64'(rx_w[0]), 64'h3C);
    chk("t1 rx_len",  64'(rxl_w[0]), 64'd8);

    // quad lanes, full word
    do_load(dbe, 6'd32, 2'b10);
    for (int i = 0; i < 8; i++) begin
      chk("t2 sdo", 64'(sdo_w[0]), 64'(dbe[31-4*i -: 4]));
      sdi = x1234[31-4*i -: 4]; shift_en = 1'b1;
      step();
    end
    shift_en = 1'b0;
    chk("t2 done", 64'(done_w[0]), 64'd1);
    step();
    chk("t2 rx_data", 64'(rx_w[0]), 64'h12345678);

    // quad lanes, partial final group
    do_load(32'hB400_0000, 6'd6, 2'b10);
    chk("t3 sdo0", 64'(sdo_w[0]), 64'hB);
    sdi = 4'hF; shift_en = 1'b1;
    step();
    chk("t3 sdo1", 64'(sdo_w[0][3:2]), 64'b01);
    step();
    shift_en = 1'b0;
    chk("t3 done", 64'(done_w[0]), 64'd1);
    step();
    chk("t3 rx_data", 64'(rx_w[0]), 64'h3F);
    chk("t3 rx_len",  64'(rxl_w[0]), 64'd6);

    // abort after 3 shifts, with an ignored load during SHIFT
    do_load(32'h8100_0000, 6'd8, 2'b00);
    sdi = 4'h1; shift_en = 1'b1;
    step(); step(); step();
    shift_en = 1'b0;
    load_data = 32'hFFFF_FFFF; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("t5 sdo held", 64'(sdo_w[0][0]), 64'd0);
    chk("t5 busy", 64'(busy_w[0]), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5 busy after abort", 64'(busy_w[0]), 64'd0);
    chk("t5 rx kept", 64'(rx_w[0]), 64'h3F);
    step();

    // zero length and clamped length
    do_load(32'hFFFF_FFFF, 6'd0, 2'b00);
    chk("t4 busy len0", 64'(busy_w[0]), 64'd0);
    chk("t4 done len0", 64'(done_w[0]), 64'd1);
    step();
    chk("t4 rx len0", 64'(rx_w[0]), 64'd0);
    chk("t4 rx_len len0", 64'(rxl_w[0]), 64'd0);
    do_load($urandom, 6'd40, 2'b10);
    for (int i = 0; i < 8; i++) begin
      sdi = 4'($urandom); shift_en = 1'b1;
      step();
    end
    shift_en = 1'b0;
    chk("t4 done clamp", 64'(done_w[0]), 64'd1);
    step();
    chk("t4 rx_len clamp", 64'(rxl_w[0]), 64'd32);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = $urandom;
      load_len   = 6'($urandom_range(0, 40));
      load_mode  = 2'($urandom);
      shift_en   = ($urandom_range(0, 9) < 7);
      abort      = ($urandom_range(0, 49) == 0);
      sdi        = 4'($urandom);
      step();
    end
    load_valid = 1'b0; shift_en = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // asynchronous reset mid-transfer
    do_load(32'hF0F0_0000, 6'd16, 2'b00);
    shift_en = 1'b1; sdi = 4'h1;
    for (int i = 0; i < 5; i++) step();
    shift_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("t6 rst load_ready", 64'(lr_w[m]), 64'd1);
      chk("t6 rst busy", 64'(busy_w[m]), 64'd0);
      chk("t6 rst done", 64'(done_w[m]), 64'd0);
      chk("t6 rst sdo", 64'(sdo_w[m]), 64'd0);
      chk("t6 rst rx_data", 64'(rx_w[m]), 64'd0);
      chk("t6 rst rx_len", 64'(rxl_w[m]), 64'd0);
    end
    step();
    rst_n = 1'b1;
    step();
    do_load(32'h0000_0001, 6'd8, 2'b00);
    chk("t6 lsb first bit", 64'(sdo_w[1][0]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      sdi = (i == 0) ? 4'h1 : 4'h0; shift_en = 1'b1;
      step();
    end
    shift_en = 1'b0;
    step();
    chk("t6 lsb rx_data", 64'(rx_w[1]), 64'h01);
    chk("t6 msb rx_data", 64'(rx_w[0]), 64'h80);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
